conv_mem_writer: RTL

Parametrised write-address generator for convolution-layer output memories. Walks an IMG_W x IMG_H output image once per channel, holding each address for CYCLES_PER_PIXEL qualified cycles while the MAC datapath produces a pixel, and strobes one write per pixel. It sits between the layer's convolution engine and its output RAM, replacing the fixed 8x8x3, 25-cycle per-layer counters with one configurable block. It adds start/restart, stall, write-strobe and busy/done signalling.

---
 rtl/conv_mem_writer.sv | 101 ++++++++++
 1 files changed

// File: rtl/conv_mem_writer.sv
// Write-address generator for convolution output memories: walks IMG_W x IMG_H
// pixels per channel, holding each address for CYCLES_PER_PIXEL enabled cycles.
module conv_mem_writer #(
  parameter int IMG_W            = 8,
  parameter int IMG_H            = 8,
  parameter int CHANNELS         = 3,
  parameter int CYCLES_PER_PIXEL = 25,
  parameter int START_DELAY      = 15,
  localparam int PIXELS = IMG_W * IMG_H,
  localparam int ADDR_W = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic [CH_W-1:0]   channel,
  output logic              wr_en,
  output logic              wr_last,
  output logic              busy,
  output logic              done
);
  localparam int CYC_W = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;
  localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [CH_W-1:0]    ch_n;
  logic [CYC_W-1:0]   cyc, cyc_n;
  logic [DLY_W-1:0]   dly, dly_n;
  logic               addr_end, ch_end;

  // Exact terminal compares keep non-power-of-two sizes in range.
  assign addr_end = (addr == ADDR_W'(PIXELS - 1));
  assign ch_end   = (channel == CH_W'(CHANNELS - 1));
  assign wr_en    = (state == RUN) && enable && (cyc == CYC_W'(CYCLES_PER_PIXEL - 1));
  assign wr_last  = wr_en && addr_end && ch_end;
  assign busy     = (state == DELAY) || (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_n = state;
    addr_n  = addr;
    ch_n    = channel;
    cyc_n   = cyc;
    dly_n   = dly;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          addr_n  = '0;
          ch_n    = '0;
          cyc_n   = '0;
          dly_n   = '0;
          state_n = (START_DELAY > 0) ? DELAY : RUN;
        end
      end
      DELAY: begin
        dly_n = dly + 1'b1;
        if (dly == DLY_W'(START_DELAY - 1)) state_n = RUN;
      end
      RUN: begin
        if (wr_en) begin
          cyc_n = '0;
          if (addr_end) begin
            addr_n = '0;
            if (ch_end) begin
              ch_n    = '0;
              state_n = DONE;
            end else begin
              ch_n = channel + 1'b1;
            end
          end else begin
            addr_n = addr + 1'b1;
          end
        end else if (enable) begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      channel <= '0;
      cyc     <= '0;
      dly     <= '0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      channel <= ch_n;
      cyc     <= cyc_n;
      dly     <= dly_n;
    end
  end
endmodule
